sobel_window_3x3: RTL

//   Downstream of the BRAM read / byte-select stage: consumes one 8-bit grey pixel per cycle in raster order.

---
 rtl/sobel_window_3x3.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sobel_window_3x3.sv
// 3x3 Sobel gradient window over a raster pixel stream, two line buffers, two-stage pipeline.
// Define SOBEL_THRESH_EN to binarize the magnitude against THRESH instead of saturating it.
module sobel_window_3x3 #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned THRESH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pix_in,
    input  logic       pix_in_valid,
    input  logic       sof,
    output logic [7:0] pix_out,
    output logic       pix_out_valid,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    if (IMG_W < 3 || IMG_H < 3 || THRESH > 255) begin : g_param_check
        $error("sobel_window_3x3: IMG_W/IMG_H must be >= 3 and THRESH must fit in 8 bits");
    end

    typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            s1_valid_q, s1_valid_d;
    logic            out_valid_d;
    logic            done_d;

    // lb0 holds line r-2, lb1 holds line r-1 at the column being written.
    logic [7:0]      lb0 [IMG_W];
    logic [7:0]      lb1 [IMG_W];
    logic [7:0]      win_q [3][3];
    logic [7:0]      win_d [3][3];

    logic            restart;
    logic            accept;
    logic [CW-1:0]   pos_col;
    logic [RW-1:0]   pos_row;
    logic            last_col;
    logic            last_row;

    logic [10:0]     gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0]     gx_d, gy_d;
    logic [10:0]     gx_q, gy_q;
    logic [10:0]     abs_gx, abs_gy;
    logic [10:0]     mag;
    logic [7:0]      pix_out_d;

    assign restart  = pix_in_valid && sof;
    assign accept   = restart || (pix_in_valid && (state_q == StFill || state_q == StRun));
    assign pos_col  = restart ? '0 : col_q;
    assign pos_row  = restart ? '0 : row_q;
    assign last_col = (pos_col == CW'(IMG_W - 1));
    assign last_row = (pos_row == RW'(IMG_H - 1));
    assign busy     = (state_q == StFill) || (state_q == StRun);

    // Window as it will look once the incoming pixel has been shifted in.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
        end
        win_d[0][2] = lb0[pos_col];
        win_d[1][2] = lb1[pos_col];
        win_d[2][2] = pix_in;
    end

    // Sums are at most 1020, so the 11-bit wrapped difference is the exact signed result.
    always_comb begin
        gx_pos = {3'b000, win_d[0][2]} + {2'b00, win_d[1][2], 1'b0} + {3'b000, win_d[2][2]};
        gx_neg = {3'b000, win_d[0][0]} + {2'b00, win_d[1][0], 1'b0} + {3'b000, win_d[2][0]};
        gy_pos = {3'b000, win_d[2][0]} + {2'b00, win_d[2][1], 1'b0} + {3'b000, win_d[2][2]};
        gy_neg = {3'b000, win_d[0][0]} + {2'b00, win_d[0][1], 1'b0} + {3'b000, win_d[0][2]};
        gx_d   = gx_pos - gx_neg;
        gy_d   = gy_pos - gy_neg;
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        s1_valid_d = 1'b0;
        done_d     = 1'b0;

        if (accept) begin
            col_d = last_col ? '0 : pos_col + 1'b1;
            row_d = last_col ? pos_row + 1'b1 : pos_row;
        end

        if (restart) begin
            state_d = StFill;
        end else begin
            unique case (state_q)
                StIdle: ;
                StFill: begin
                    if (pix_in_valid && pos_row == RW'(2) && pos_col == '0) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (pix_in_valid) begin
                        s1_valid_d = (pos_col >= CW'(2));
                        if (last_row && last_col) begin
                            state_d = StDone;
                            col_d   = '0;
                            row_d   = '0;
                        end
                    end
                end
                StDone: begin
                    if (!s1_valid_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A restart discards the result still sitting in stage 1.
    assign out_valid_d = s1_valid_q && !restart;

    always_comb begin
        abs_gx = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
        abs_gy = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
        mag    = abs_gx + abs_gy;
`ifdef SOBEL_THRESH_EN
        pix_out_d = (mag >= 11'(THRESH)) ? 8'hFF : 8'h00;
`else
        pix_out_d = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_q         <= '0;
            s1_valid_q    <= 1'b0;
            pix_out       <= 8'h00;
            pix_out_valid <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            s1_valid_q    <= s1_valid_d;
            pix_out_valid <= out_valid_d;
            frame_done    <= done_d;
            if (out_valid_d) begin
                pix_out <= pix_out_d;
            end
        end
    end

    // Datapath storage carries no reset; validity is tracked by the flags above.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[pos_col] <= lb1[pos_col];
            lb1[pos_col] <= pix_in;
            win_q        <= win_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
        end
    end

endmodule
